// File: rtl/cmp_pkg.sv
// Shared compare-code encoding, branch funct3 values and resolver FSM states.
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/cmp_code_decoder.sv
// Combinational decode of a one-hot {gt, eq, lt} compare code against a branch funct3.
module cmp_code_decoder
  import cmp_pkg::*;
(
  input  logic [2:0] cmp_code,
  input  logic [2:0] funct3,
  output logic       taken_c,
  output logic       illegal_c
);

  logic is_eq;
  logic is_gt;
  logic is_lt;

  assign is_eq = (cmp_code == CMP_EQ);
  assign is_gt = (cmp_code == CMP_GT);
  assign is_lt = (cmp_code == CMP_LT);

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3)
      F3_BEQ:           taken_c = is_eq;
      F3_BNE:           taken_c = !is_eq;
      F3_BLT, F3_BLTU:  taken_c = is_lt;
      F3_BGE, F3_BGEU:  taken_c = is_gt | is_eq;
      default:          illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_branch_resolver.sv
// Bit-serial MSB-first magnitude comparator resolving a branch funct3 to taken/not-taken.
// Optional CMP_EARLY_EXIT_EN: finish as soon as the first differing slice is seen.
module cmp_branch_resolver
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [2:0]       cmp_code,
  output logic             illegal
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic [2:0]       code_q, code_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;

  logic [STEP-1:0]  a_slice;
  logic [STEP-1:0]  b_slice;
  logic [2:0]       code_run_c;
  logic             dec_taken_c;
  logic             dec_illegal_c;
  logic             signed_c;
  logic [WIDTH-1:0] msb_flip_c;
  logic             run_done_c;

  // Flipping both sign bits maps signed order onto the unsigned scan.
  assign signed_c   = (funct3 == F3_BLT) || (funct3 == F3_BGE);
  assign msb_flip_c = {signed_c, {(WIDTH-1){1'b0}}};

  // Operands shift left each RUN cycle, so the current slice is always on top.
  assign a_slice = a_q[WIDTH-1 -: STEP];
  assign b_slice = b_q[WIDTH-1 -: STEP];

  always_comb begin
    code_run_c = code_q;
    if (code_q == CMP_EQ) begin
      if (a_slice > b_slice)      code_run_c = CMP_GT;
      else if (a_slice < b_slice) code_run_c = CMP_LT;
    end
  end

  cmp_code_decoder u_dec (
    .cmp_code  (code_run_c),
    .funct3    (f3_q),
    .taken_c   (dec_taken_c),
    .illegal_c (dec_illegal_c)
  );

  always_comb begin
`ifdef CMP_EARLY_EXIT_EN
    run_done_c = (cnt_q == CW'(N - 1)) || (code_run_c != CMP_EQ);
`else
    run_done_c = (cnt_q == CW'(N - 1));
`endif
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    f3_d        = f3_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = op_a ^ msb_flip_c;
          b_d     = op_b ^ msb_flip_c;
          f3_d    = funct3;
          code_d  = CMP_EQ;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d    = a_q << STEP;
        b_d    = b_q << STEP;
        code_d = code_run_c;
        cnt_d  = cnt_q + CW'(1);
        if (run_done_c) begin
          state_d     = DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          taken_d     = dec_taken_c;
          illegal_d   = dec_illegal_c;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f3_q        <= '0;
      code_q      <= CMP_EQ;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f3_q        <= f3_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign cmp_code  = code_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cmp_branch_resolver.sv
// Self-checking bench for cmp_branch_resolver: directed table, corner sequences, random vs. model.
module tb_cmp_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [2:0]  cmp_code;
  logic        illegal;

  int n_checks;
  int n_errors;

  cmp_branch_resolver #(.WIDTH(32), .STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .funct3    (funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .cmp_code  (cmp_code),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [2:0]  code;
    logic        tk;
    logic        ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic compare and funct3 truth table.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       output logic [2:0] code, output logic tk, output logic ill,
                       output int lat);
    bit sgn;
    bit gt;
    bit lt;
    int h;
    sgn = (f3 == 3'b100) || (f3 == 3'b101);
    if (sgn) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    code = gt ? 3'b100 : (lt ? 3'b001 : 3'b010);
    ill  = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:         tk = !gt && !lt;
      3'b001:         tk = gt || lt;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        tk = 1'b0;
    endcase
    h = -1;
    for (int i = 31; i >= 0; i--) begin
      if (h < 0 && a[i] != b[i]) h = i;
    end
`ifdef CMP_EARLY_EXIT_EN
    lat = (h < 0) ? 32 : 32 - h;
`else
    lat = 32;
`endif
  endtask

  // One full transaction with out_ready high; checks result, latency and re-accept.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input bit use_exp, input logic [2:0] e_code,
                        input logic e_tk, input logic e_ill);
    logic [2:0] m_code;
    logic       m_tk;
    logic       m_ill;
    int         m_lat;
    int         lat;
    model(a, b, f3, m_code, m_tk, m_ill, m_lat);
    if (use_exp) begin
      m_code = e_code;
      m_tk   = e_tk;
      m_ill  = e_ill;
    end
    out_ready = 1'b1;
    chk({name, " in_ready_before"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; funct3 = f3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    chk({name, " latency"}, 32'(lat), 32'(m_lat));
    chk({name, " cmp_code"}, 32'(cmp_code), 32'(m_code));
    chk({name, " taken"}, 32'(taken), 32'(m_tk));
    chk({name, " illegal"}, 32'(illegal), 32'(m_ill));
    @(posedge clk); #1;
    chk({name, " in_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  vec_t       tbl[10];
  logic [2:0] hold_code;
  logic       hold_tk;
  int         waited;
  int         stale;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    funct3    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset taken", 32'(taken), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset cmp_code", 32'(cmp_code), 32'b010);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset cmp_code", 32'(cmp_code), 32'b010);

    tbl[0] = '{32'h1234_5678, 32'h1234_5678, 3'b000, 3'b010, 1'b1, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 3'b001, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 3'b100, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 3'b101, 3'b010, 1'b1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 3'b010, 3'b010, 1'b0, 1'b1};
    tbl[5] = '{32'h8000_0000, 32'h0000_0000, 3'b111, 3'b100, 1'b1, 1'b0};
    tbl[6] = '{32'h0000_0005, 32'h0000_0005, 3'b001, 3'b010, 1'b0, 1'b0};
    tbl[7] = '{32'h0000_0005, 32'h0000_0006, 3'b001, 3'b001, 1'b1, 1'b0};
    tbl[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 3'b101, 3'b100, 1'b1, 1'b0};
    tbl[9] = '{32'h0000_0001, 32'h0000_0002, 3'b011, 3'b001, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].f3, 1'b1,
             tbl[i].code, tbl[i].tk, tbl[i].ill);
    end

    // Reset in the middle of RUN aborts the operation with no stale result.
    op_a = 32'h0000_0001; op_b = 32'h0000_0002; funct3 = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun reset in_ready", 32'(in_ready), 32'd1);
    chk("midrun reset out_valid", 32'(out_valid), 32'd0);
    chk("midrun reset cmp_code", 32'(cmp_code), 32'b010);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) stale++;
    end
    chk("no stale result", 32'(stale), 32'd0);

    // Back-pressure: DONE holds with out_ready low, busy requests ignored.
    out_ready = 1'b0;
    op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; funct3 = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("stall reached done", 32'(out_valid), 32'd1);
    hold_code = cmp_code;
    hold_tk   = taken;
    chk("stall code", 32'(cmp_code), 32'b100);
    chk("stall taken", 32'(taken), 32'd0);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 3 == 1);
      op_a = 32'h0; op_b = 32'h7; funct3 = 3'b000;
      @(posedge clk); #1;
      chk($sformatf("stall hold %0d", c),
          {27'd0, out_valid, in_ready, taken, cmp_code == hold_code, hold_tk},
          {27'd0, 1'b1, 1'b0, hold_tk, 1'b1, hold_tk});
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handshake no same-edge accept", {30'd0, in_ready, out_valid}, 32'b10);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle after handshake", 32'(in_ready), 32'd1);

    // Random operands, with equal and single-bit-different pairs mixed in.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          k;
      ra = $urandom;
      k  = $urandom_range(0, 3);
      if (k == 0)      rb = ra;
      else if (k == 1) rb = ra ^ (32'd1 << $urandom_range(0, 31));
      else             rb = $urandom;
      run_op($sformatf("rnd%0d", r), ra, rb, 3'($urandom_range(0, 7)), 1'b0,
             3'b000, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_branch_resolver.md
# cmp_branch_resolver

Multi-cycle, bit-serial magnitude comparator and branch-condition resolver for the NovaEdge32 execute stage. It scans two operands MSB-first one slice per cycle and folds each slice into the team's one-hot compare code {gt, eq, lt}. It then decodes the final code against a RISC-V branch funct3 into a taken/not-taken decision. It consumes compare codes and turns them into control decisions, so it is the decoding end of the compare-code interface.

## Interface
- WIDTH, 32: operand width in bits.
- STEP, 1: bits examined per cycle; must divide WIDTH; N = WIDTH/STEP.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op_a  in  WIDTH  first operand (rs1).
- op_b  in  WIDTH  second operand (rs2).
- funct3  in  3  branch condition.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- taken  out  1  branch taken.
- cmp_code  out  3  final {gt, eq, lt}, one-hot.
- illegal  out  1  funct3 is 010 or 011.

## Operation
- FSM states: IDLE, RUN, DONE. in_ready is 1 exactly when state is IDLE (combinational).
- IDLE → RUN when in_valid && in_ready. Latch op_a, op_b, funct3, clear slice counter, set code = EQ (3'b010).
- Signed conditions (funct3 100, 101): invert bit WIDTH-1 of both latched operands at load, so an unsigned scan gives the signed order.
- RUN: each cycle compares slice [WIDTH-1-i·STEP -: STEP] as unsigned.
  - While code == EQ: code ← GT if a_slice > b_slice, LT if a_slice < b_slice, else EQ.
  - Once code is non-EQ it holds. The counter increments each cycle.
  - RUN → DONE after slice N-1 is processed.
- DONE: out_valid = 1. taken, cmp_code and illegal are stable. DONE → IDLE on out_valid && out_ready.
- Decode:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT / 110 BLTU: taken = lt.
  - 101 BGE / 111 BGEU: taken = gt | eq.
  - 010 and 011: illegal = 1 and taken = 0. The compare still runs and cmp_code is still valid.
- cmp_code is always exactly one-hot.

## Timing
- Reset values while rst_n is low and after release:
  - State IDLE, so in_ready = 1.
  - out_valid = 0, taken = 0, illegal = 0.
  - cmp_code = 3'b010.
  - Counter = 0.
- Latency: out_valid rises N edges after the accepting edge (32 for the default parameters).
- Throughput with out_ready held high: one operation per N+2 cycles, made up of:
  - the accept edge,
  - N RUN edges,
  - one DONE handshake edge.
- in_valid while busy: ignored. in_ready = 0 in RUN and DONE, so no input is latched.
- Output stall: if out_ready is low, DONE holds indefinitely and outputs do not change.
- Reset mid-operation: the operation is aborted, the FSM returns to IDLE and the result is discarded. No out_valid is produced for it.
- Output handshake and re-accept: in_ready rises the cycle after the output handshake. A new request cannot be accepted on the same edge as the output handshake.

## Configuration
- CMP_EARLY_EXIT_EN defined: RUN → DONE on the edge where a slice first makes code non-EQ, or after slice N-1, whichever comes first. Operands differing in the top slice produce out_valid 1 edge after accept.
- Not defined: RUN always lasts exactly N cycles, giving fixed latency regardless of data.
- Final taken, cmp_code and illegal are identical in both builds.

## Structure
- Shared package cmp_pkg holds:
  - CMP_GT = 3'b100, CMP_EQ = 3'b010, CMP_LT = 3'b001;
  - the funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - the FSM state typedef.
- Sub-module cmp_code_decoder: purely combinational. It maps (cmp_code, funct3) → (taken, illegal) and is reusable by the single-cycle branch path.

## Test plan
- Reset: assert rst_n = 0 mid-RUN → in_ready = 1, out_valid = 0, cmp_code = 3'b010 immediately. No stale result appears after release.
- BEQ, a = 0x1234_5678, b = 0x1234_5678 → cmp_code = 010, taken = 1, out_valid 32 cycles after accept.
- BLT (signed), a = 0xFFFF_FFFF, b = 0x0000_0001 → cmp_code = 001, taken = 1. Same operands with BLTU → cmp_code = 100, taken = 0.
- BGE, a = 0x8000_0000, b = 0x8000_0000 → taken = 1. funct3 = 010 on the same operands → illegal = 1, taken = 0.
- Back-pressure: hold out_ready = 0 for 10 cycles with in_valid pulsed during the stall → outputs stable, second request not accepted. Raising out_ready → handshake, then in_ready = 1 next cycle.
- With CMP_EARLY_EXIT_EN, STEP = 1, a = 0x8000_0000, b = 0 (BGEU) → out_valid 1 edge after accept, taken = 1. Without the macro → 32 edges, same result.
